// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
package shift_add_multiplier_pkg;

  localparam int unsigned DEFAULT_SIZE = 8;

  // Controller state encoding; 2'd3 is unreachable and recovers to IDLE.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/full_adder.sv
// Parameterised SIZE-bit adder with carry out, shared with the ALU datapath.
module full_adder #(
  parameter int unsigned SIZE = 8
) (
  input  logic [SIZE-1:0] in1,
  input  logic [SIZE-1:0] in2,
  output logic [SIZE-1:0] out,
  output logic            cout
);

  // Zero-extend both operands so the carry lands in the extra bit.
  always_comb begin
    {cout, out} = {1'b0, in1} + {1'b0, in2};
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned radix-2 shift-and-add multiplier: one partial
// product per cycle through a shared full_adder, SIZE+1 cycles start->done.
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int unsigned SIZE = DEFAULT_SIZE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SIZE-1:0]   multiplicand,
  input  logic [SIZE-1:0]   multiplier,
  output logic              busy,
  output logic              done,
  output logic [2*SIZE-1:0] product
);

  localparam int unsigned CW = $clog2(SIZE + 1);

  state_e              state_q, state_d;
  logic [SIZE-1:0]     m_q, m_d;
  logic [SIZE-1:0]     q_q, q_d;
  logic [SIZE-1:0]     acc_q, acc_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [2*SIZE-1:0]   product_q, product_d;

  logic [SIZE-1:0]     addend;
  logic [SIZE-1:0]     fa_out;
  logic                fa_cout;

  // Add M only when the current multiplier LSB is set.
  always_comb begin
    addend = q_q[0] ? m_q : '0;
  end

  full_adder #(.SIZE(SIZE)) u_full_adder (
    .in1  (acc_q),
    .in2  (addend),
    .out  (fa_out),
    .cout (fa_cout)
  );

  // Next-state, datapath shift and registered Moore output decode.
  // The carry bit C is always shifted back to zero at the end of an
  // iteration, so the adder carry is fed straight into the ACC MSB
  // instead of being held in a separate flop.
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    q_d       = q_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          m_d     = multiplicand;
          q_d     = multiplier;
          acc_d   = '0;
          cnt_d   = CW'(SIZE);
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d = {fa_cout, fa_out[SIZE-1:1]};
        q_d   = {fa_out[0], q_q[SIZE-1:1]};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d   = S_DONE;
          product_d = {acc_d, q_d};
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      m_q       <= '0;
      q_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      q_q       <= q_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule
